multi_interval_counter: RTL and testbench
=========================================

Name: multi_interval_counter

Overview:
- N-channel successor to the single interval counter. Each channel divides clk by its own programmable interval and counts the resulting ticks.
- Adds per-channel enable, clear, wrap/saturate mode, a tick strobe and a sticky overflow flag.
- Sits beside the control FSM, which drives the shared 8-bit run state; channels are read by the performance/timing logic.

Parameters:
- NCH, 4, number of independent channels (1..16).
- CNT_W, 32, width of each channel's event counter.
- IV_W, 32, width of each channel's interval and phase register.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- state  in  8  global run state: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT; any other code means HOLD.
- interval  in  NCH*IV_W  per-channel interval; channel i occupies bits [i*IV_W +: IV_W].
- ch_en  in  NCH  per-channel enable, effective only in RUN.
- ch_mode  in  NCH  per-channel mode: 0 = wrap, 1 = saturate.
- clr  in  NCH  per-channel synchronous clear strobe.
- counter  out  NCH*CNT_W  per-channel event count, registered.
- count_interval  out  NCH*IV_W  per-channel phase, registered.
- tick  out  NCH  one-cycle pulse, registered; high in the cycle the counter shows its new value.
- ovf  out  NCH  sticky overflow/saturation flag.

Behaviour:
- Priority per channel, highest first: rst > state==RESET > clr[i] > state/ch_en logic.
- rst or state==RESET: counter=0, count_interval=1, tick=0, ovf=0 on every channel.
- clr[i]: channel i only; counter=0, count_interval=1, tick=0, ovf=0. Clear wins over a coincident tick.
- HALT: count_interval reloads to 1, counter and ovf hold, tick=0. Resuming RUN restarts a full interval.
- HOLD (undefined state code): all registers hold, tick=0.
- RUN with ch_en[i]=0: counter, count_interval and ovf hold; tick=0.
- RUN with ch_en[i]=1:
  - Effective interval ei = max(interval[i], 1), so interval 0 behaves as 1.
  - If count_interval >= ei: count_interval <= 1 and a tick event occurs.
  - Otherwise count_interval <= count_interval + 1 and no event.
  - If interval is lowered below the current phase, the next cycle fires one event and reloads to 1. There is no catch-up burst.
- Tick event, wrap mode: counter <= counter + 1, modulo 2^CNT_W; tick=1. When counter goes from all-ones to 0, ovf <= 1.
- Tick event, saturate mode:
  - counter < max: increment, tick=1.
  - counter == max: counter holds, ovf <= 1, tick=0.
- Latency:
  - First tick occurs ei cycles after RUN asserts from a reset phase.
  - Steady-state tick period is ei cycles.
- interval, ch_mode and ch_en are sampled every cycle; changes take effect on the next edge.
- ovf clears only via rst, RESET or clr[i].
- Channels are fully independent and share only clk, rst and state.

Decomposition:
- Shared package multi_counter_pkg holds the state codes STATE_RESET, STATE_RUN, STATE_HALT and the mode codes MODE_WRAP, MODE_SAT.
- One sub-module, interval_counter_chan, implements a single channel: phase register, counter, tick, ovf. It takes CNT_W and IV_W parameters.
- The top level is a generate loop over NCH that slices the flattened buses.

Test Plan:
1. rst, then RUN, ch0 interval=3, en=1, wrap -> count_interval 1,2,3,1,2,3..., counter0=1 after 3rd edge, 2 after 6th; tick0 pulses on edges 3 and 6.
2. Interval=0 on ch1 and interval=1 on ch2, RUN for 10 cycles -> both counters = 10, tick high every cycle.
3. CNT_W=4 instance, interval=1, wrap -> after 16 ticks counter=0, ovf=1. Same in saturate -> counter stays 15 from tick 15 on, ovf=1 on the 16th event, tick=0 thereafter.
4. RUN interval=5, HALT at phase=4 for 3 cycles, then RUN -> counter unchanged during HALT, phase=1 on resume, next tick 5 cycles after resume.
5. clr[0] asserted in the same cycle as a tick event -> counter0=0, ovf0=0, tick0=0; other channels unaffected. rst mid-run -> all outputs to reset values next edge.
6. state=8'd7 mid-run for 4 cycles -> counter and count_interval frozen, tick=0. Return to RUN resumes from the frozen phase.

Source files
------------

// File: rtl/multi_counter_pkg.sv
// Shared run-state and channel-mode codes for the multi-channel interval counter.
package multi_counter_pkg;

    localparam logic [7:0] STATE_RESET = 8'd0;
    localparam logic [7:0] STATE_RUN   = 8'd1;
    localparam logic [7:0] STATE_HALT  = 8'd2;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/interval_counter_chan.sv
// One channel: divides clk by a programmable interval and counts the resulting ticks,
// with clear, wrap/saturate mode, a registered tick strobe and a sticky overflow flag.
module interval_counter_chan
    import multi_counter_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int IV_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       state,
    input  logic [IV_W-1:0]  interval,
    input  logic             en,
    input  logic             mode,
    input  logic             clr,
    output logic [CNT_W-1:0] counter,
    output logic [IV_W-1:0]  count_interval,
    output logic             tick,
    output logic             ovf
);

    logic [IV_W-1:0] ei;
    logic            fire;
    logic            cnt_max;

    // An interval of 0 behaves as 1; ">=" gives a single reload when the interval is lowered.
    assign ei      = (interval == '0) ? IV_W'(1) : interval;
    assign fire    = (count_interval >= ei);
    assign cnt_max = (counter == '1);

    always_ff @(posedge clk) begin
        if (rst || state == STATE_RESET || clr) begin
            counter        <= '0;
            count_interval <= IV_W'(1);
            tick           <= 1'b0;
            ovf            <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                STATE_RUN: begin
                    if (en) begin
                        if (fire) begin
                            count_interval <= IV_W'(1);
                            if (mode == MODE_SAT && cnt_max) begin
                                ovf <= 1'b1;
                            end else begin
                                counter <= counter + CNT_W'(1);
                                tick    <= 1'b1;
                                if (cnt_max) ovf <= 1'b1;
                            end
                        end else begin
                            count_interval <= count_interval + IV_W'(1);
                        end
                    end
                end
                // Halt keeps the count but forces a full interval on resume.
                STATE_HALT: count_interval <= IV_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_interval_counter.sv
// N-channel interval counter: one independent interval_counter_chan per channel,
// all sharing clk, rst and the global run state.
module multi_interval_counter
    import multi_counter_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 32,
    parameter int IV_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           state,
    input  logic [NCH*IV_W-1:0]  interval,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       ch_mode,
    input  logic [NCH-1:0]       clr,
    output logic [NCH*CNT_W-1:0] counter,
    output logic [NCH*IV_W-1:0]  count_interval,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       ovf
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        interval_counter_chan #(
            .CNT_W(CNT_W),
            .IV_W (IV_W)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .state         (state),
            .interval      (interval[i*IV_W +: IV_W]),
            .en            (ch_en[i]),
            .mode          (ch_mode[i]),
            .clr           (clr[i]),
            .counter       (counter[i*CNT_W +: CNT_W]),
            .count_interval(count_interval[i*IV_W +: IV_W]),
            .tick          (tick[i]),
            .ovf           (ovf[i])
        );
    end

endmodule

// File: tb/tb_multi_interval_counter.sv
// Directed bench for multi_interval_counter: a 4-channel 32-bit instance and a
// 2-channel 4-bit instance for the wrap/saturate boundary.
module tb_multi_interval_counter;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   state;
    logic [127:0] interval;
    logic [3:0]   ch_en, ch_mode, clr;
    logic [127:0] counter, count_interval;
    logic [3:0]   tick, ovf;

    logic [7:0]   s_state;
    logic [7:0]   s_interval;
    logic [1:0]   s_en, s_mode, s_clr;
    logic [7:0]   s_counter, s_count_interval;
    logic [1:0]   s_tick, s_ovf;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multi_interval_counter #(.NCH(4), .CNT_W(32), .IV_W(32)) u_dut (
        .clk(clk), .rst(rst), .state(state), .interval(interval),
        .ch_en(ch_en), .ch_mode(ch_mode), .clr(clr),
        .counter(counter), .count_interval(count_interval), .tick(tick), .ovf(ovf)
    );

    multi_interval_counter #(.NCH(2), .CNT_W(4), .IV_W(4)) u_small (
        .clk(clk), .rst(rst), .state(s_state), .interval(s_interval),
        .ch_en(s_en), .ch_mode(s_mode), .clr(s_clr),
        .counter(s_counter), .count_interval(s_count_interval), .tick(s_tick), .ovf(s_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_ch(input string tag, input int i, input logic [31:0] cnt,
                            input logic [31:0] ph, input logic t, input logic o);
        check({tag, ".counter"}, 64'(counter[i*32 +: 32]), 64'(cnt));
        check({tag, ".phase"}, 64'(count_interval[i*32 +: 32]), 64'(ph));
        check({tag, ".tick"}, 64'(tick[i]), 64'(t));
        check({tag, ".ovf"}, 64'(ovf[i]), 64'(o));
    endtask

    initial begin
        logic [31:0] exp_ph [6];
        logic [31:0] exp_cnt[6];
        logic        exp_tk [6];
        exp_ph  = '{2, 3, 1, 2, 3, 1};
        exp_cnt = '{0, 0, 1, 1, 1, 2};
        exp_tk  = '{0, 0, 1, 0, 0, 1};

        rst = 1'b1; state = 8'd0; interval = '0; ch_en = '0; ch_mode = '0; clr = '0;
        s_state = 8'd0; s_interval = '0; s_en = '0; s_mode = '0; s_clr = '0;

        // Reset values
        step();
        for (int i = 0; i < 4; i++) check_ch($sformatf("reset.ch%0d", i), i, 0, 1, 0, 0);

        // Interval 3 on ch0, 0 on ch1, 1 on ch2, 5 on ch3 (ch3 disabled for now)
        rst = 1'b0;
        state = 8'd1;
        interval[0*32 +: 32] = 32'd3;
        interval[1*32 +: 32] = 32'd0;
        interval[2*32 +: 32] = 32'd1;
        interval[3*32 +: 32] = 32'd5;
        ch_en = 4'b0111;
        for (int e = 0; e < 6; e++) begin
            step();
            check_ch($sformatf("iv3.edge%0d", e + 1), 0, exp_cnt[e], exp_ph[e], exp_tk[e], 0);
            check($sformatf("iv0.tick.edge%0d", e + 1), 64'(tick[1]), 64'd1);
            check($sformatf("iv1.tick.edge%0d", e + 1), 64'(tick[2]), 64'd1);
        end
        for (int e = 0; e < 4; e++) step();
        check_ch("iv0.ten", 1, 10, 1, 1, 0);
        check_ch("iv1.ten", 2, 10, 1, 1, 0);
        check_ch("iv3.ten", 0, 3, 2, 0, 0);
        check_ch("disabled.ch3", 3, 0, 1, 0, 0);

        // Undefined state code freezes everything
        state = 8'd7;
        for (int e = 0; e < 4; e++) begin
            step();
            check_ch($sformatf("hold.ch0.c%0d", e), 0, 3, 2, 0, 0);
            check($sformatf("hold.ch1.cnt.c%0d", e), 64'(counter[32 +: 32]), 64'd10);
            check($sformatf("hold.ch1.tick.c%0d", e), 64'(tick[1]), 64'd0);
        end
        state = 8'd1;
        step();
        check_ch("resume.ch0.e1", 0, 3, 3, 0, 0);
        step();
        check_ch("resume.ch0.e2", 0, 4, 1, 1, 0);
        check("resume.ch1.cnt", 64'(counter[32 +: 32]), 64'd12);

        // Halt in the middle of ch3's interval of 5
        ch_en = 4'b1111;
        for (int e = 0; e < 5; e++) step();
        check_ch("iv5.first_tick", 3, 1, 1, 1, 0);
        for (int e = 0; e < 3; e++) step();
        check_ch("iv5.phase4", 3, 1, 4, 0, 0);
        state = 8'd2;
        for (int e = 0; e < 3; e++) begin
            step();
            check_ch($sformatf("halt.ch3.c%0d", e), 3, 1, 1, 0, 0);
        end
        check_ch("halt.ch0", 0, 6, 1, 0, 0);
        state = 8'd1;
        for (int e = 0; e < 4; e++) begin
            step();
            check_ch($sformatf("after_halt.ch3.e%0d", e + 1), 3, 1, e + 2, 0, 0);
        end
        step();
        check_ch("after_halt.ch3.e5", 3, 2, 1, 1, 0);
        check_ch("after_halt.ch0", 0, 7, 3, 0, 0);

        // Clear ch0 on the very edge where it would tick
        clr = 4'b0001;
        step();
        clr = 4'b0000;
        check_ch("clr.ch0", 0, 0, 1, 0, 0);
        check_ch("clr.ch1", 1, 26, 1, 1, 0);
        check_ch("clr.ch2", 2, 26, 1, 1, 0);
        check_ch("clr.ch3", 3, 2, 2, 0, 0);

        // Reset mid-run
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) check_ch($sformatf("midrst.ch%0d", i), i, 0, 1, 0, 0);
        rst = 1'b0;
        state = 8'd0;

        // 4-bit counters, interval 1: ch0 wraps, ch1 saturates
        s_interval = 8'h11;
        s_en = 2'b11;
        s_mode = 2'b10;
        s_state = 8'd1;
        for (int e = 0; e < 15; e++) step();
        check("small.t15.wrap.cnt", 64'(s_counter[3:0]), 64'd15);
        check("small.t15.wrap.ovf", 64'(s_ovf[0]), 64'd0);
        check("small.t15.sat.cnt", 64'(s_counter[7:4]), 64'd15);
        check("small.t15.sat.tick", 64'(s_tick[1]), 64'd1);
        check("small.t15.sat.ovf", 64'(s_ovf[1]), 64'd0);
        step();
        check("small.t16.wrap.cnt", 64'(s_counter[3:0]), 64'd0);
        check("small.t16.wrap.tick", 64'(s_tick[0]), 64'd1);
        check("small.t16.wrap.ovf", 64'(s_ovf[0]), 64'd1);
        check("small.t16.sat.cnt", 64'(s_counter[7:4]), 64'd15);
        check("small.t16.sat.tick", 64'(s_tick[1]), 64'd0);
        check("small.t16.sat.ovf", 64'(s_ovf[1]), 64'd1);
        step();
        check("small.t17.wrap.cnt", 64'(s_counter[3:0]), 64'd1);
        check("small.t17.wrap.ovf", 64'(s_ovf[0]), 64'd1);
        check("small.t17.sat.cnt", 64'(s_counter[7:4]), 64'd15);
        check("small.t17.sat.tick", 64'(s_tick[1]), 64'd0);
        check("small.t17.sat.ovf", 64'(s_ovf[1]), 64'd1);
        s_clr = 2'b10;
        step();
        s_clr = 2'b00;
        check("small.clr.sat.cnt", 64'(s_counter[7:4]), 64'd0);
        check("small.clr.sat.ovf", 64'(s_ovf[1]), 64'd0);
        check("small.clr.wrap.ovf", 64'(s_ovf[0]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
